// File: rtl/tmds_pkg.sv
// Shared types, default 640x480@60 timing and colour-bar table for the TMDS video sequencer.
package tmds_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // {R,G,B} on/off per bar; index 0 (white) is the leftmost bar.
    localparam logic [7:0][2:0] COLOUR_BARS = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic rgb888_t colour_bar(input logic [2:0] idx);
        logic [2:0] w_bits;
        rgb888_t    w_px;
        w_bits = COLOUR_BARS[idx];
        w_px.r = {8{w_bits[2]}};
        w_px.g = {8{w_bits[1]}};
        w_px.b = {8{w_bits[0]}};
        return w_px;
    endfunction

endpackage

// File: rtl/tmds_raster_counter.sv
// Horizontal/vertical raster counters with active, sync-window and end-of-frame decode.
module tmds_raster_counter
    import tmds_pkg::*;
#(
    parameter  int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter  int unsigned H_FP     = DEF_H_FP,
    parameter  int unsigned H_SYNC   = DEF_H_SYNC,
    parameter  int unsigned H_BP     = DEF_H_BP,
    parameter  int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter  int unsigned V_FP     = DEF_V_FP,
    parameter  int unsigned V_SYNC   = DEF_V_SYNC,
    parameter  int unsigned V_BP     = DEF_V_BP,
    localparam int unsigned HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int unsigned VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          clr,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hs_act,
    output logic          vs_act,
    output logic          eof
);

    localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (clr) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (run) begin
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    assign h_cnt  = r_h_cnt;
    assign v_cnt  = r_v_cnt;
    assign active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign hs_act = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
    assign vs_act = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
    assign eof    = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);

endmodule

// File: rtl/tmds_video_sequencer.sv
// Raster sequencer feeding the B/G/R TMDS encoders from a ready/valid pixel stream.
// Define TMDS_SEQ_PATTERN_EN to replace underflowed pixels with colour bars instead of black.
module tmds_video_sequencer
    import tmds_pkg::*;
#(
    parameter  int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter  int unsigned H_FP     = DEF_H_FP,
    parameter  int unsigned H_SYNC   = DEF_H_SYNC,
    parameter  int unsigned H_BP     = DEF_H_BP,
    parameter  int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter  int unsigned V_FP     = DEF_V_FP,
    parameter  int unsigned V_SYNC   = DEF_V_SYNC,
    parameter  int unsigned V_BP     = DEF_V_BP,
    parameter  logic        HS_POL   = 1'b0,
    parameter  logic        VS_POL   = 1'b0,
    localparam int unsigned HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int unsigned VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  enc_data_r,
    output logic [7:0]  enc_data_g,
    output logic [7:0]  enc_data_b,
    output logic [1:0]  enc_c_b,
    output logic [1:0]  enc_c_g,
    output logic [1:0]  enc_c_r,
    output logic        enc_blank,
    output logic        frame_start,
    output logic        underflow,
    output logic        busy
);

    seq_state_t    r_state;
    rgb888_t       r_pix;
    logic          r_blank;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_frame_start;
    logic          r_underflow;

    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    logic          w_active;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_eof;
    logic          w_running;
    logic          w_pix_act;
    rgb888_t       w_subst;
    rgb888_t       w_pixel;

    assign w_running = (r_state != IDLE);

    tmds_raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_raster (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (w_running),
        .clr    (!w_running),
        .h_cnt  (w_h_cnt),
        .v_cnt  (w_v_cnt),
        .active (w_active),
        .hs_act (w_hs_act),
        .vs_act (w_vs_act),
        .eof    (w_eof)
    );

    assign w_pix_act = w_running && w_active;
    assign pix_ready = w_pix_act;

`ifdef TMDS_SEQ_PATTERN_EN
    localparam int unsigned BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    logic [HW-1:0] w_band;
    assign w_band  = w_h_cnt / HW'(BAR_W);
    assign w_subst = colour_bar((w_band > HW'(7)) ? 3'd7 : w_band[2:0]);
`else
    assign w_subst = '0;
`endif

    assign w_pixel = pix_valid ? rgb888_t'(pix_data) : w_subst;

    // Timing never stalls: a missing pixel is substituted and flagged, not waited for.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pix         <= '0;
            r_blank       <= 1'b1;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE:    if (enable) r_state <= RUN;
                RUN:     if (!enable) r_state <= DRAIN;
                DRAIN: begin
                    if (enable)     r_state <= RUN;
                    else if (w_eof) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            r_pix         <= w_pix_act ? w_pixel : '0;
            r_blank       <= !w_pix_act;
            r_hsync       <= (w_running && w_hs_act) ? HS_POL : ~HS_POL;
            r_vsync       <= (w_running && w_vs_act) ? VS_POL : ~VS_POL;
            r_frame_start <= w_pix_act && (w_h_cnt == '0) && (w_v_cnt == '0);
            r_underflow   <= w_pix_act && !pix_valid;
        end
    end

    assign enc_data_r  = r_pix.r;
    assign enc_data_g  = r_pix.g;
    assign enc_data_b  = r_pix.b;
    assign enc_c_b     = {r_vsync, r_hsync};
    assign enc_c_g     = 2'b00;
    assign enc_c_r     = 2'b00;
    assign enc_blank   = r_blank;
    assign frame_start = r_frame_start;
    assign underflow   = r_underflow;
    // Timing keeps running through DRAIN, so the sequencer stays busy until the frame ends.
    assign busy        = w_running;

endmodule

// File: tb/tb_tmds_video_sequencer.sv
// Directed bench for tmds_video_sequencer on a shrunken 16x8 raster (24x14 totals).
module tb_tmds_video_sequencer;

    localparam int HT = 24;
    localparam int VT = 14;
    localparam int FRAME = HT * VT;
    localparam logic [23:0] SUBST =
`ifdef TMDS_SEQ_PATTERN_EN
        24'hFFFF00;
`else
        24'h000000;
`endif

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  enc_data_r;
    logic [7:0]  enc_data_g;
    logic [7:0]  enc_data_b;
    logic [1:0]  enc_c_b;
    logic [1:0]  enc_c_g;
    logic [1:0]  enc_c_r;
    logic        enc_blank;
    logic        frame_start;
    logic        underflow;
    logic        busy;

    tmds_video_sequencer #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (2),
        .HS_POL   (1'b0), .VS_POL (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .enc_data_r  (enc_data_r),
        .enc_data_g  (enc_data_g),
        .enc_data_b  (enc_data_b),
        .enc_c_b     (enc_c_b),
        .enc_c_g     (enc_c_g),
        .enc_c_r     (enc_c_r),
        .enc_blank   (enc_blank),
        .frame_start (frame_start),
        .underflow   (underflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pos   = 0;

    typedef struct {
        int          h;
        int          v;
        logic        valid;
        logic [23:0] data;
        logic        exp_ready;
        logic [23:0] exp_rgb;
        logic        exp_blank;
        logic [1:0]  exp_cb;
        logic        exp_fs;
        logic        exp_uf;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        pos++;
    endtask

    task automatic step_to(input int target);
        while (pos < target) step();
    endtask

    function automatic logic [23:0] rgb_out();
        return {enc_data_r, enc_data_g, enc_data_b};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bad_cyc;
        int          n_ready;
        int          n_hs;
        int          n_blank_lo;
        int          n_fs;
        int          fs_idx;
        int          n_vs;
        int          n_uf;
        int          cnt;
        logic [23:0] drv;
        logic        act;

        //            h   v  vld data          rdy exp_rgb      blk cb     fs  uf
        vecs[0]  = '{0,  0, 1, 24'h123456, 1, 24'h123456, 0, 2'b11, 1, 0};
        vecs[1]  = '{5,  0, 1, 24'hABCDEF, 1, 24'hABCDEF, 0, 2'b11, 0, 0};
        vecs[2]  = '{15, 0, 1, 24'h010203, 1, 24'h010203, 0, 2'b11, 0, 0};
        vecs[3]  = '{16, 0, 1, 24'hFFFFFF, 0, 24'h000000, 1, 2'b11, 0, 0};
        vecs[4]  = '{18, 0, 1, 24'h000000, 0, 24'h000000, 1, 2'b10, 0, 0};
        vecs[5]  = '{20, 0, 1, 24'h000000, 0, 24'h000000, 1, 2'b10, 0, 0};
        vecs[6]  = '{21, 0, 1, 24'h000000, 0, 24'h000000, 1, 2'b11, 0, 0};
        vecs[7]  = '{3,  5, 0, 24'h777777, 1, SUBST,       0, 2'b11, 0, 1};
        vecs[8]  = '{0,  7, 1, 24'h89ABCD, 1, 24'h89ABCD, 0, 2'b11, 0, 0};
        vecs[9]  = '{0,  8, 1, 24'h89ABCD, 0, 24'h000000, 1, 2'b11, 0, 0};
        vecs[10] = '{19, 10, 1, 24'h000000, 0, 24'h000000, 1, 2'b00, 0, 0};
        vecs[11] = '{5,  11, 1, 24'h000000, 0, 24'h000000, 1, 2'b01, 0, 0};
        vecs[12] = '{5,  12, 1, 24'h000000, 0, 24'h000000, 1, 2'b11, 0, 0};
        vecs[13] = '{23, 13, 1, 24'h000000, 0, 24'h000000, 1, 2'b11, 0, 0};

        rst_n     = 1'b0;
        enable    = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;

        // Reset state
        #12;
        chk("rst pix_ready", 32'(pix_ready), 0);
        chk("rst enc_blank", 32'(enc_blank), 1);
        chk("rst enc_c_b", 32'(enc_c_b), 32'h3);
        chk("rst rgb", 32'(rgb_out()), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst fs/uf", 32'({frame_start, underflow}), 0);
        chk("rst c_g/c_r", 32'({enc_c_g, enc_c_r}), 0);
        #11 rst_n = 1'b1;
        step();
        chk("idle busy", 32'(busy), 0);
        chk("idle ready", 32'(pix_ready), 0);

        enable    = 1'b1;
        pix_valid = 1'b1;
        step();
        pos = 0;

        // Directed vectors across the first frame
        for (int i = 0; i < 14; i++) begin
            step_to(vecs[i].v * HT + vecs[i].h);
            pix_valid = vecs[i].valid;
            pix_data  = vecs[i].data;
            #1;
            chk($sformatf("vec%0d ready", i), 32'(pix_ready), 32'(vecs[i].exp_ready));
            step();
            chk($sformatf("vec%0d rgb", i), 32'(rgb_out()), 32'(vecs[i].exp_rgb));
            chk($sformatf("vec%0d blank", i), 32'(enc_blank), 32'(vecs[i].exp_blank));
            chk($sformatf("vec%0d c_b", i), 32'(enc_c_b), 32'(vecs[i].exp_cb));
            chk($sformatf("vec%0d frame_start", i), 32'(frame_start), 32'(vecs[i].exp_fs));
            chk($sformatf("vec%0d underflow", i), 32'(underflow), 32'(vecs[i].exp_uf));
            chk($sformatf("vec%0d c_g/c_r", i), 32'({enc_c_g, enc_c_r}), 0);
            pix_valid = 1'b1;
            pix_data  = '0;
        end

        // Full second frame against a cycle model
        step_to(FRAME);
        bad_cyc = 0; n_ready = 0; n_hs = 0; n_vs = 0; n_blank_lo = 0;
        n_fs = 0; fs_idx = -1; n_uf = 0;
        for (int i = 0; i < FRAME; i++) begin
            int h;
            int v;
            h = i % HT;
            v = i / HT;
            act = (h < 16) && (v < 8);
            drv = {8'(i), 8'(i + 7), 8'(i + 13)};
            pix_data = drv;
            #1;
            if (pix_ready) n_ready++;
            if (pix_ready !== act) bad_cyc++;
            step();
            if (enc_blank !== !act) bad_cyc++;
            if (enc_c_b[0] !== !((h >= 18) && (h < 21))) bad_cyc++;
            if (enc_c_b[1] !== !((v >= 10) && (v < 12))) bad_cyc++;
            if (rgb_out() !== (act ? drv : 24'h0)) bad_cyc++;
            if ({enc_c_g, enc_c_r} !== 4'b0) bad_cyc++;
            if (!enc_blank) n_blank_lo++;
            if (!enc_c_b[0]) n_hs++;
            if (!enc_c_b[1]) n_vs++;
            if (underflow) n_uf++;
            if (frame_start) begin
                n_fs++;
                if (fs_idx < 0) fs_idx = i;
            end
        end
        chk("frame cycle model", 32'(bad_cyc), 0);
        chk("frame ready count", 32'(n_ready), 128);
        chk("frame blank-low count", 32'(n_blank_lo), 128);
        chk("frame hsync-low count", 32'(n_hs), 3 * VT);
        chk("frame vsync-low count", 32'(n_vs), 2 * HT);
        chk("frame_start count", 32'(n_fs), 1);
        chk("frame_start period", 32'(fs_idx + FRAME), 32'(FRAME));
        chk("frame underflow count", 32'(n_uf), 0);

        // Drain: drop at v=3, re-enable at v=5, drop again at v=6
        pix_data = '0;
        step_to(2 * FRAME + 3 * HT);
        enable = 1'b0;
        cnt = 0;
        while (pos < 2 * FRAME + 5 * HT) begin
            step();
            if (!busy) cnt++;
        end
        chk("drain busy held", 32'(cnt), 0);
        enable = 1'b1;
        step_to(2 * FRAME + 5 * HT + 7);
        pix_data = 24'h0F1E2D;
        #1;
        chk("re-enable ready h7", 32'(pix_ready), 1);
        step();
        chk("re-enable rgb h7", 32'(rgb_out()), 32'h0F1E2D);
        pix_data = '0;
        step_to(2 * FRAME + 5 * HT + 18);
        step();
        chk("re-enable hsync h18", 32'(enc_c_b), 32'h2);
        step_to(2 * FRAME + 6 * HT);
        enable = 1'b0;
        step_to(2 * FRAME + 7 * HT + 2);
        chk("drain ready active", 32'(pix_ready), 1);
        chk("drain busy", 32'(busy), 1);
        step_to(3 * FRAME - 1);
        chk("drain busy last pixel", 32'(busy), 1);
        step();
        chk("post-drain busy", 32'(busy), 0);
        chk("post-drain ready", 32'(pix_ready), 0);
        step();
        chk("idle blank", 32'(enc_blank), 1);
        chk("idle c_b", 32'(enc_c_b), 32'h3);
        chk("idle no frame_start", 32'(frame_start), 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (pix_ready || busy || !enc_blank) cnt++;
        end
        chk("idle hold", 32'(cnt), 0);

        // Asynchronous reset mid-frame at h=8, v=4
        enable = 1'b1;
        step();
        pos = 0;
        pix_data = 24'hCAFE00;
        step_to(4 * HT + 8);
        chk("pre-reset rgb", 32'(rgb_out()), 32'hCAFE00);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst ready", 32'(pix_ready), 0);
        chk("async rst blank", 32'(enc_blank), 1);
        chk("async rst rgb", 32'(rgb_out()), 0);
        chk("async rst c_b", 32'(enc_c_b), 32'h3);
        chk("async rst busy", 32'(busy), 0);
        #1 rst_n = 1'b1;
        step();
        chk("restart ready at 0,0", 32'(pix_ready), 1);
        pix_data = 24'h5A5A5A;
        step();
        chk("restart frame_start", 32'(frame_start), 1);
        chk("restart rgb", 32'(rgb_out()), 32'h5A5A5A);
        chk("restart blank", 32'(enc_blank), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
